seven_seg_scan_receiver: RTL and testbench

- Receive side of the board's multiplexed 7-segment interface.
- Samples the active-low `seg`/`an` lines produced by a display driver, rejects transition ghosting, decodes each stable digit back to a 4-bit code, and publishes a full 8-digit frame snapshot.
- Used for on-chip loopback self-check of timer/stopwatch displays and as a bench monitor.

---
 rtl/seven_seg_pkg.sv | 47 ++++
 rtl/seven_seg_scan_receiver_if.sv | 22 ++
 rtl/seven_seg_scan_receiver_seg_pattern_decoder.sv | 34 +++
 rtl/seven_seg_scan_receiver.sv | 167 ++++++++++++++++
 tb/tb_seven_seg_scan_receiver.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions used by the display drivers and the scan
// receiver: active-low segment patterns (bit6=g .. bit0=a), 4-bit digit
// codes, receiver FSM states and the sampled scan-line record.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_S     = 7'b0010010;  // same glyph as 5
  localparam logic [6:0] SEG_T     = 7'b0000111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_S       = 4'hA;
  localparam logic [3:0] CODE_T       = 4'hB;
  localparam logic [3:0] CODE_E       = 4'hC;
  localparam logic [3:0] CODE_INVALID = 4'hE;
  localparam logic [3:0] CODE_BLANK   = 4'hF;

  typedef enum logic [1:0] {
    ST_SETTLING = 2'd0,
    ST_ACCEPT   = 2'd1,
    ST_LOCKED   = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [7:0] an;   // active-low anodes
    logic [6:0] seg;  // active-low cathodes
  } scan_sample_t;

  // Position of the lowest low bit of an active-low anode vector.
  function automatic logic [2:0] anode_index(input logic [7:0] an_n);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--)
      if (!an_n[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/seven_seg_scan_receiver_if.sv
// Scan-line / frame bus of the 7-segment receiver.
//   master : drives seg_in/an_in, observes the published frame
//   slave  : the receiver
interface seven_seg_scan_receiver_if;
  logic [6:0]  seg_in;
  logic [7:0]  an_in;
  logic [31:0] digits;
  logic        frame_valid;
  logic        frame_strobe;
  logic        multi_anode;
  logic        seg_error;

  modport master (
    output seg_in, an_in,
    input  digits, frame_valid, frame_strobe, multi_anode, seg_error
  );

  modport slave (
    input  seg_in, an_in,
    output digits, frame_valid, frame_strobe, multi_anode, seg_error
  );
endinterface

// File: rtl/seven_seg_scan_receiver_seg_pattern_decoder.sv
// seg_pattern_decoder: active-low 7-segment pattern -> 4-bit code.
//   i_seg     : pattern, bit6=g .. bit0=a
//   o_code    : decoded code (CODE_INVALID when unknown)
//   o_invalid : pattern not in the code table
module seg_pattern_decoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_code,
  output logic       o_invalid
);

  always_comb begin
    o_code    = CODE_INVALID;
    o_invalid = 1'b0;
    case (i_seg)
      SEG_0:     o_code = 4'h0;
      SEG_1:     o_code = 4'h1;
      SEG_2:     o_code = 4'h2;
      SEG_3:     o_code = 4'h3;
      SEG_4:     o_code = 4'h4;
      SEG_5:     o_code = 4'h5;  // "S" is indistinguishable, reported as 5
      SEG_6:     o_code = 4'h6;
      SEG_7:     o_code = 4'h7;
      SEG_8:     o_code = 4'h8;
      SEG_9:     o_code = 4'h9;
      SEG_T:     o_code = CODE_T;
      SEG_E:     o_code = CODE_E;
      SEG_BLANK: o_code = CODE_BLANK;
      default:   o_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_receiver.sv
// seven_seg_scan_receiver: samples a multiplexed active-low 7-segment scan,
// drops transition ghosts, decodes stable digits and publishes 8-digit frames.
//   clk, reset_n      : clock, async active-low reset
//   bus.seg_in/an_in  : scan lines from the display driver
//   bus.digits        : last published frame, nibble i = digit i
//   bus.frame_valid   : digits holds a frame published since reset/timeout
//   bus.frame_strobe  : one-cycle pulse when digits updates
//   bus.multi_anode   : pulse, stable pattern had >= 2 anodes low
//   bus.seg_error     : pulse, accepted segment pattern not decodable
module seven_seg_scan_receiver
  import seven_seg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic                      clk,
  input logic                      reset_n,
  seven_seg_scan_receiver_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] IDLE_FIRE   = TW'(TIMEOUT_CYCLES - 2);

  // ---------------- input synchronizer and stability counter ----------------
  scan_sample_t [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]                  r_cnt;
  scan_sample_t                   w_s;
  scan_sample_t                   w_next;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_next = r_sync[SYNC_STAGES-2];

  // r_cnt is aligned with w_s: it counts how many earlier samples equal the
  // current one, so it clears on the same edge that w_s changes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '1;
      r_cnt  <= '0;
    end else begin
      r_sync[0] <= {bus.an_in, bus.seg_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      if (w_next != w_s)            r_cnt <= '0;
      else if (r_cnt != SETTLE_LAST) r_cnt <= r_cnt + CW'(1);
    end
  end

  // ---------------- classification / decode of the current sample ----------
  logic       w_an_none, w_an_one, w_an_multi;
  logic [3:0] w_code;
  logic       w_invalid;

  assign w_an_none  = &w_s.an;
  assign w_an_one   = $onehot(~w_s.an);
  assign w_an_multi = !w_an_none && !w_an_one;

  seg_pattern_decoder u_dec (
    .i_seg     (w_s.seg),
    .o_code    (w_code),
    .o_invalid (w_invalid)
  );

  // ---------------- FSM, frame buffer, timeout ------------------------------
  rx_state_e       r_state;
  logic            r_acc_one, r_acc_none;
  logic [2:0]      r_acc_idx;
  logic [3:0]      r_acc_code;
  logic [7:0][3:0] r_buf;
  logic [7:0]      r_written;
  logic [2:0]      r_last_idx;
  logic            r_first, r_gap;
  logic [TW-1:0]   r_idle;
  logic [31:0]     r_digits;
  logic            r_valid, r_strobe, r_multi, r_segerr;

  logic [31:0]     w_publish;
  logic            w_accept_one;
  logic            w_boundary;

  // Positions not written during the closing frame read as blank.
  always_comb begin
    w_publish = '1;
    for (int i = 0; i < 8; i++)
      if (r_written[i]) w_publish[4*i +: 4] = r_buf[i];
  end

  assign w_accept_one = (r_state == ST_ACCEPT) && r_acc_one;
  // A new frame starts when the scan wraps to a lower index, or revisits the
  // same index after a blank slot (single-digit displays).
  assign w_boundary   = !r_first &&
                        ((r_acc_idx < r_last_idx) || ((r_acc_idx == r_last_idx) && r_gap));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_SETTLING;
      r_acc_one  <= 1'b0;
      r_acc_none <= 1'b0;
      r_acc_idx  <= '0;
      r_acc_code <= CODE_BLANK;
      r_buf      <= '1;
      r_written  <= '0;
      r_last_idx <= '0;
      r_first    <= 1'b1;
      r_gap      <= 1'b0;
      r_idle     <= '0;
      r_digits   <= '1;
      r_valid    <= 1'b0;
      r_strobe   <= 1'b0;
      r_multi    <= 1'b0;
      r_segerr   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      r_multi  <= 1'b0;
      r_segerr <= 1'b0;

      case (r_state)
        ST_SETTLING: if (r_cnt == SETTLE_LAST) begin
          // Capture the stable sample so a change on this edge cannot leak in.
          r_state    <= ST_ACCEPT;
          r_acc_one  <= w_an_one;
          r_acc_none <= w_an_none;
          r_acc_idx  <= anode_index(w_s.an);
          r_acc_code <= w_code;
          r_multi    <= w_an_multi;
          r_segerr   <= w_an_one && w_invalid;
        end
        ST_ACCEPT: r_state <= ST_LOCKED;
        ST_LOCKED: if (r_cnt == '0) r_state <= ST_SETTLING;
        default:   r_state <= ST_SETTLING;
      endcase

      if ((r_state == ST_ACCEPT) && r_acc_none) r_gap <= 1'b1;

      if (w_accept_one) begin
        if (w_boundary) begin
          r_digits <= w_publish;
          r_strobe <= 1'b1;
          r_valid  <= 1'b1;
        end
        r_buf[r_acc_idx] <= r_acc_code;
        r_written  <= (w_boundary ? 8'h00 : r_written) | (8'h01 << r_acc_idx);
        r_last_idx <= r_acc_idx;
        r_first    <= 1'b0;
        r_gap      <= 1'b0;
        r_idle     <= '0;
      end else if (r_idle != IDLE_LAST) begin
        r_idle <= r_idle + TW'(1);
        if (r_idle == IDLE_FIRE) begin
          r_digits  <= '1;
          r_valid   <= 1'b0;
          r_written <= '0;
          r_first   <= 1'b1;
        end
      end
    end
  end

  assign bus.digits       = r_digits;
  assign bus.frame_valid  = r_valid;
  assign bus.frame_strobe = r_strobe;
  assign bus.multi_anode  = r_multi;
  assign bus.seg_error    = r_segerr;

endmodule

// File: tb/tb_seven_seg_scan_receiver.sv
module tb_seven_seg_scan_receiver;

  localparam int SETTLE = 4;
  localparam int TMO    = 2000;
  localparam logic [7:0] AN_IDLE = 8'hFF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seven_seg_scan_receiver_if bus();

  seven_seg_scan_receiver #(
    .SYNC_STAGES    (2),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Glyph table 0-9, t, E, blank and the codes they stand for.
  logic [6:0] pat_tab [13] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0000111, 7'b0000110,
                               7'b1111111};
  logic [3:0] code_tab [13] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                4'h8, 4'h9, 4'hB, 4'hC, 4'hF};

  int checks = 0;
  int errors = 0;

  // Observed pulse counts.
  int obs_strobe = 0, obs_multi = 0, obs_segerr = 0;
  always @(negedge clk) begin
    if (bus.frame_strobe === 1'b1) obs_strobe++;
    if (bus.multi_anode  === 1'b1) obs_multi++;
    if (bus.seg_error    === 1'b1) obs_segerr++;
  end

  // Reference model: frame-level view of the scan.
  logic [3:0]  m_buf [8];
  bit          m_wr  [8];
  bit          m_first, m_gap, m_valid, m_to;
  int          m_last, m_idle;
  logic [31:0] m_digits;
  int          e_strobe = 0, e_multi = 0, e_segerr = 0;
  logic [7:0]  cur_an;
  logic [6:0]  cur_seg;
  int          cur_len;
  bit          cur_done;

  logic [6:0]  fr_seg [8];
  bit          fr_en  [8];

  function automatic logic [3:0] ref_decode(input logic [6:0] seg, output bit bad);
    logic [3:0] c;
    c   = 4'hE;
    bad = 1'b1;
    for (int i = 0; i < 13; i++)
      if (pat_tab[i] == seg) begin c = code_tab[i]; bad = 1'b0; end
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin m_buf[i] = 4'hF; m_wr[i] = 1'b0; end
    m_first = 1'b1; m_gap = 1'b0; m_valid = 1'b0; m_to = 1'b0;
    m_last = 0; m_idle = 0; m_digits = '1;
    cur_an = AN_IDLE; cur_seg = SEG_OFF; cur_len = 0; cur_done = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] an, input logic [6:0] seg);
    int nlow, idx;
    bit bad;
    logic [3:0] code;
    nlow = 0; idx = 0;
    for (int i = 0; i < 8; i++) if (!an[i]) begin nlow++; idx = i; end
    if (nlow == 0) m_gap = 1'b1;
    else if (nlow > 1) e_multi++;
    else begin
      code = ref_decode(seg, bad);
      if (bad) e_segerr++;
      if (!m_first && (idx < m_last || (idx == m_last && m_gap))) begin
        for (int i = 0; i < 8; i++) begin
          m_digits[4*i +: 4] = m_wr[i] ? m_buf[i] : 4'hF;
          m_wr[i] = 1'b0;
        end
        m_valid = 1'b1;
        e_strobe++;
      end
      m_buf[idx] = code; m_wr[idx] = 1'b1; m_last = idx;
      m_first = 1'b0; m_gap = 1'b0; m_idle = 0; m_to = 1'b0;
    end
  endtask

  // Stimulus never comes near the timeout threshold except on purpose, so a
  // generous margin keeps the model free of cycle-exact bookkeeping.
  task automatic model_idle_check();
    if (!m_to && m_idle > TMO + 40) begin
      m_to = 1'b1; m_digits = '1; m_valid = 1'b0; m_first = 1'b1;
      for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
    end
  endtask

  // Hold a pattern on the pins for len sampling edges. Equal consecutive
  // patterns form one run; a run is accepted once it lasts SETTLE samples.
  task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int len);
    if ({an, seg} != {cur_an, cur_seg}) begin
      cur_an = an; cur_seg = seg; cur_len = 0; cur_done = 1'b0;
    end
    bus.an_in  = an;
    bus.seg_in = seg;
    if (!cur_done && cur_len + len >= SETTLE) begin
      model_idle_check();
      model_accept(an, seg);
      cur_done = 1'b1;
    end
    cur_len += len;
    m_idle  += len;
    model_idle_check();
    repeat (len) @(posedge clk);
    #1;
  endtask

  function automatic int slot_len(input int slot);
    return (slot > 0) ? slot : int'($urandom_range(20, 100));
  endfunction

  // One scan pass from digit `first`, each enabled digit followed by a blank
  // slot; optionally inject short foreign glitches after digits.
  task automatic scan_frame(input int slot, input int first, input bit glitch);
    for (int d = first; d < 8; d++) if (fr_en[d]) begin
      drive(~(8'h01 << d), fr_seg[d], slot_len(slot));
      if (glitch && $urandom_range(0, 3) == 0)
        drive(8'b1110_0111, 7'($urandom), int'($urandom_range(1, SETTLE - 1)));
      drive(AN_IDLE, SEG_OFF, slot_len(slot));
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " digits"}, bus.digits, m_digits);
    chk({tag, " frame_valid"}, 32'(bus.frame_valid), 32'(m_valid));
    chk({tag, " strobes"}, 32'(obs_strobe), 32'(e_strobe));
    chk({tag, " multi_anode"}, 32'(obs_multi), 32'(e_multi));
    chk({tag, " seg_error"}, 32'(obs_segerr), 32'(e_segerr));
  endtask

  task automatic set_stopwatch();
    for (int d = 0; d < 8; d++) begin fr_en[d] = 1'b1; fr_seg[d] = 7'b1111111; end
    fr_seg[0] = 7'b0110000;  // 3
    fr_seg[1] = 7'b0011001;  // 4
    fr_seg[2] = 7'b1000000;  // 0
    fr_seg[3] = 7'b1000000;  // 0
    fr_seg[7] = 7'b0010010;  // S
  endtask

  initial begin
    int r;
    bus.an_in  = AN_IDLE;
    bus.seg_in = SEG_OFF;
    model_reset();
    #12;
    chk("reset digits", bus.digits, 32'hFFFF_FFFF);
    chk("reset frame_valid", 32'(bus.frame_valid), 32'd0);
    chk("reset pulses", {29'd0, bus.frame_strobe, bus.multi_anode, bus.seg_error}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Stopwatch display: first frame publishes nothing, second publishes it.
    set_stopwatch();
    scan_frame(100, 0, 1'b0);
    chk_model("frame1");
    scan_frame(100, 0, 1'b0);
    chk_model("frame2");
    chk("stopwatch digits", bus.digits, 32'h5FFF_0043);

    // Three-cycle foreign pattern between slots is never accepted.
    drive(8'hFE, fr_seg[0], 100);
    drive(8'b1001_1111, 7'b0101010, 3);
    drive(AN_IDLE, SEG_OFF, 100);
    scan_frame(100, 1, 1'b0);
    chk_model("glitch");
    chk("glitch digits", bus.digits, 32'h5FFF_0043);

    // Two anodes low, stable: one multi_anode pulse, frame unaffected.
    drive(8'b1111_1100, 7'b0110000, 20);
    drive(AN_IDLE, SEG_OFF, 100);
    scan_frame(100, 0, 1'b0);
    chk_model("multi");
    chk("multi digits", bus.digits, 32'h5FFF_0043);

    // Undecodable digit0 pattern: seg_error, published as E next frame.
    fr_seg[0] = 7'b0101010;
    scan_frame(100, 0, 1'b0);
    fr_seg[0] = 7'b0110000;
    scan_frame(100, 0, 1'b0);
    chk_model("seg_error");
    chk("seg_error digits", bus.digits, 32'h5FFF_004E);

    // Idle display: timeout blanks the frame without a strobe.
    drive(AN_IDLE, SEG_OFF, TMO + 100);
    chk_model("timeout");
    chk("timeout digits", bus.digits, 32'hFFFF_FFFF);
    chk("timeout frame_valid", 32'(bus.frame_valid), 32'd0);
    scan_frame(100, 0, 1'b0);
    chk_model("post-timeout frame1");
    scan_frame(100, 0, 1'b0);
    chk_model("post-timeout frame2");

    // Random displays, random slot lengths, random ghost glitches.
    for (int f = 0; f < 8; f++) begin
      for (int d = 0; d < 8; d++) begin
        fr_en[d] = ($urandom_range(0, 3) != 0);
        r = int'($urandom_range(0, 13));
        fr_seg[d] = (r == 13) ? 7'($urandom) : pat_tab[r];
      end
      scan_frame(0, 0, 1'b1);
      chk_model($sformatf("random%0d", f));
    end

    // Reset mid-frame, then a single-digit display.
    set_stopwatch();
    drive(8'hFE, fr_seg[0], 50);
    drive(AN_IDLE, SEG_OFF, 10);
    reset_n = 1'b0;
    #1;
    chk("midreset digits", bus.digits, 32'hFFFF_FFFF);
    chk("midreset frame_valid", 32'(bus.frame_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    for (int d = 0; d < 8; d++) fr_en[d] = (d == 0);
    scan_frame(100, 0, 1'b0);
    chk_model("single1");
    scan_frame(100, 0, 1'b0);
    chk_model("single2");
    chk("single digits", bus.digits, 32'hFFFF_FFF3);
    chk("single frame_valid", 32'(bus.frame_valid), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
